// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache and D-cache miss handlers: block fills and D-side write-throughs.
// Latency: grant and first read one cycle after the request is sampled in IDLE; write completes in that same cycle.
// Backpressure: one owner at a time; a waiting requester holds req until granted; fills are never preempted.
// Optional feature: define ARB_RR_EN for round-robin arbitration (default is fixed priority, D over I).
module mem_arbiter #(
  parameter int WORDS_PER_BLK = 8,
  parameter int ADDR_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_req,
  input  logic [ADDR_W-1:0]                i_addr,
  output logic                             i_grant,
  output logic                             i_data_vld,
  output logic                             i_done,
  input  logic                             d_req,
  input  logic                             d_wr,
  input  logic [ADDR_W-1:0]                d_addr,
  input  logic [ADDR_W-1:0]                d_wdata,
  output logic                             d_grant,
  output logic                             d_data_vld,
  output logic                             d_done,
  output logic [ADDR_W-1:0]                rd_data,
  output logic [$clog2(WORDS_PER_BLK)-1:0] rd_word,
  output logic                             busy,
  output logic                             mem_en,
  output logic                             mem_wr,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [ADDR_W-1:0]                mem_wdata,
  input  logic [ADDR_W-1:0]                mem_rdata,
  input  logic                             mem_valid
);

  // Word index width and byte-offset width of one block (16-bit words).
  localparam int WIDX_W = $clog2(WORDS_PER_BLK);
  localparam int OFF_W  = WIDX_W + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [WIDX_W:0]   ISS_ONE   = (WIDX_W+1)'(1);
  localparam logic [WIDX_W-1:0] RCV_ONE   = WIDX_W'(1);
  localparam logic [WIDX_W-1:0] RCV_LAST  = WIDX_W'(WORDS_PER_BLK-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_WRITE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_d_q, owner_d_d;  // 1 = D-cache owns the current transaction
  logic [ADDR_W-1:0]   addr_q, addr_d;        // block base for fills, full address for writes
  logic [ADDR_W-1:0]   wdata_q, wdata_d;
  logic [WIDX_W:0]     iss_cnt_q, iss_cnt_d;  // extra MSB marks "all reads issued"
  logic [WIDX_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic                pick_d;                // arbitration result in IDLE: 1 = D wins
  logic [ADDR_W-1:0]   fill_off;

`ifdef ARB_RR_EN
  logic                last_d_q, last_d_d;    // 1 = D was the most recent owner

  // Round-robin: on a tie the requester that did not own memory last wins.
  always_comb begin
    pick_d   = d_req && (!i_req || !last_d_q);
    last_d_d = last_d_q;
    if (state_q == S_IDLE && (i_req || d_req)) begin
      last_d_d = pick_d;
    end
  end

  // Last-owner flop; resets to D so the first tie goes to I.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  // Fixed priority: D always wins a tie.
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Byte offset of the next read; wraps inside the block because it is OR-ed onto the base.
  assign fill_off = {{(ADDR_W-OFF_W){1'b0}}, iss_cnt_q[WIDX_W-1:0], 1'b0};
  assign rd_word  = rcv_cnt_q;
  assign busy     = (state_q != S_IDLE);

  // Next-state logic and all memory/cache-side outputs.
  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    iss_cnt_d  = iss_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    i_grant    = 1'b0;
    i_data_vld = 1'b0;
    i_done     = 1'b0;
    d_grant    = 1'b0;
    d_data_vld = 1'b0;
    d_done     = 1'b0;
    rd_data    = '0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        iss_cnt_d = '0;
        rcv_cnt_d = '0;
        if (i_req || d_req) begin
          owner_d_d = pick_d;
          if (pick_d && d_wr) begin
            state_d = S_WRITE;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            state_d = S_FILL;
            addr_d  = (pick_d ? d_addr : i_addr) & BASE_MASK;
          end
        end
      end

      S_FILL: begin
        i_grant = !owner_d_q;
        d_grant = owner_d_q;
        rd_data = mem_rdata;
        // One read per cycle until the whole block has been requested.
        if (!iss_cnt_q[WIDX_W]) begin
          mem_en    = 1'b1;
          mem_addr  = addr_q | fill_off;
          iss_cnt_d = iss_cnt_q + ISS_ONE;
        end
        // Returned words are steered to the owner; the last one ends the fill.
        if (mem_valid) begin
          i_data_vld = !owner_d_q;
          d_data_vld = owner_d_q;
          rcv_cnt_d  = rcv_cnt_q + RCV_ONE;
          if (rcv_cnt_q == RCV_LAST) begin
            i_done  = !owner_d_q;
            d_done  = owner_d_q;
            state_d = S_RELEASE;
          end
        end
      end

      S_WRITE: begin
        d_grant   = 1'b1;
        d_done    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = S_RELEASE;
      end

      S_RELEASE: begin
        iss_cnt_d = '0;
        rcv_cnt_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured request and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_d_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle-latency memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_data_vld, i_done;
  logic        d_grant, d_data_vld, d_done;
  logic [15:0] rd_data;
  logic [2:0]  rd_word;
  logic        busy, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid;
  logic        mem_flush;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.WORDS_PER_BLK(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_vld(i_data_vld), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data_vld(d_data_vld), .d_done(d_done),
    .rd_data(rd_data), .rd_word(rd_word), .busy(busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  // Memory model: a read issued in cycle c returns in cycle c+4 with data = addr ^ 0xA5A5.
  // It is not reset by rst_n, so reads in flight across a reset still return.
  logic [3:0]  pv;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    if (mem_flush) pv <= 4'b0;
    else           pv <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_valid = pv[3];
  assign mem_rdata = pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " ctl"}, 32'({i_grant, i_data_vld, i_done, d_grant, d_data_vld, d_done, busy, mem_en, mem_wr}), 32'h0);
    chk({nm, " addr/wdata"}, {mem_addr, mem_wdata}, 32'h0);
    chk({nm, " rd_word/rd_data"}, {13'h0, rd_word, rd_data}, 32'h0);
  endtask

  // Called in the first FILL cycle. Runs the fill to done, checking issue addresses,
  // returned words and exclusivity, then walks through RELEASE into IDLE.
  task automatic fill_run(input bit is_d, input bit drop_first, input logic [15:0] base, input string nm);
    int nvld, niss;
    bit done, other, lost, bad_rd, bad_iss;
    nvld = 0; niss = 0; done = 0; other = 0; lost = 0; bad_rd = 0; bad_iss = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (mem_en) begin
        if (mem_wr || mem_addr !== base + 16'(2 * niss)) bad_iss = 1;
        niss++;
      end
      if (is_d ? i_grant : d_grant) other = 1;
      if (!(is_d ? d_grant : i_grant)) lost = 1;
      if (is_d ? d_data_vld : i_data_vld) begin
        if (32'(rd_word) != nvld || rd_data !== ((base + 16'(2 * nvld)) ^ 16'hA5A5)) bad_rd = 1;
        nvld++;
        if (drop_first) begin
          if (is_d) d_req = 1'b0; else i_req = 1'b0;
        end
      end
      if (is_d ? d_done : i_done) begin
        done = 1;
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
      end else begin
        tick();
      end
    end
    chk({nm, " done seen"}, 32'(done), 32'd1);
    chk({nm, " words returned"}, 32'(nvld), 32'd8);
    chk({nm, " reads issued"}, 32'(niss), 32'd8);
    chk({nm, " issue addr"}, 32'(bad_iss), 32'd0);
    chk({nm, " rd_word/rd_data"}, 32'(bad_rd), 32'd0);
    chk({nm, " exclusive grant"}, 32'({other, lost}), 32'd0);
    tick();
    chk({nm, " release"}, 32'({i_grant, d_grant, busy, mem_en}), 32'b0010);
    tick();
    chk({nm, " back to idle"}, 32'({i_grant, d_grant, busy}), 32'd0);
  endtask

  typedef struct {
    logic        igrant;
    logic        en;
    logic [15:0] addr;
    logic        vld;
    logic [2:0]  word;
    logic        done;
    logic        busy;
  } row_t;

  row_t tbl [14];

  initial begin : main
    bit          win_d, first_d;
    int          nv, stale, bad;
    logic [15:0] exp_rd;

    // Expected per-cycle behaviour of an I fill at 0x1236 with L=4 (row k-1 = cycle T+k).
    tbl[0]  = '{1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0};

    rst_n = 1'b0; mem_flush = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    #3;
    chk_zero("reset");
    tick();
    tick();
    mem_flush = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle after reset", 32'(busy), 32'd0);

    // I fill alone, table-driven.
    i_addr = 16'h1236; i_req = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk($sformatf("ifill c%0d i_grant", k + 1), 32'(i_grant), 32'(tbl[k].igrant));
      chk($sformatf("ifill c%0d mem_en", k + 1), 32'({mem_en, mem_wr}), 32'({tbl[k].en, 1'b0}));
      chk($sformatf("ifill c%0d mem_addr", k + 1), 32'(mem_addr), 32'(tbl[k].addr));
      chk($sformatf("ifill c%0d i_data_vld", k + 1), 32'(i_data_vld), 32'(tbl[k].vld));
      chk($sformatf("ifill c%0d rd_word", k + 1), 32'(rd_word), 32'(tbl[k].word));
      chk($sformatf("ifill c%0d i_done", k + 1), 32'(i_done), 32'(tbl[k].done));
      chk($sformatf("ifill c%0d busy", k + 1), 32'(busy), 32'(tbl[k].busy));
      chk($sformatf("ifill c%0d d-side quiet", k + 1), 32'({d_grant, d_data_vld, d_done}), 32'd0);
      if (tbl[k].vld) begin
        exp_rd = (16'h1230 + {12'h0, tbl[k].word, 1'b0}) ^ 16'hA5A5;
        chk($sformatf("ifill c%0d rd_data", k + 1), 32'(rd_data), 32'(exp_rd));
      end
      if (tbl[k].done) i_req = 1'b0;
    end

    // D single-word write.
    d_addr = 16'h0040; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    tick();
    chk("write ctl", 32'({mem_en, mem_wr, d_grant, d_done, i_grant, busy}), 32'b111101);
    chk("write addr/data", {mem_addr, mem_wdata}, 32'h0040BEEF);
    d_req = 1'b0; d_wr = 1'b0;
    tick();
    chk("write release", 32'({mem_en, mem_wr, d_grant, d_done, busy}), 32'b00001);
    tick();
    chk("write idle", 32'(busy), 32'd0);

    // Two ties in a row: fixed priority serves D both times; round-robin serves I both times
    // (D was last owner before each tie).
    for (int t = 0; t < 2; t++) begin
      i_addr = 16'h2000; d_addr = 16'h3008; i_req = 1'b1; d_req = 1'b1;
      tick();
      win_d = d_grant;
`ifdef ARB_RR_EN
      chk($sformatf("tie%0d winner (1=D)", t), 32'({d_grant, i_grant}), 32'b01);
`else
      chk($sformatf("tie%0d winner (1=D)", t), 32'({d_grant, i_grant}), 32'b10);
`endif
      fill_run(win_d, 1'b0, win_d ? 16'h3000 : 16'h2000, $sformatf("tie%0d first", t));
      tick();
      chk($sformatf("tie%0d loser granted", t), 32'({d_grant, i_grant}), win_d ? 32'b01 : 32'b10);
      fill_run(!win_d, 1'b0, win_d ? 16'h2000 : 16'h3000, $sformatf("tie%0d second", t));
      if (t == 0) first_d = win_d;
    end
    chk("tie winners consistent", 32'(first_d), 32'(win_d));

    // d_req arrives while I owns memory: it waits until the I fill has released.
    i_addr = 16'h0100; i_req = 1'b1;
    tick();
    d_addr = 16'h4000; d_wr = 1'b0; d_req = 1'b1;
    fill_run(1'b0, 1'b0, 16'h0100, "mid-fill dreq I");
    chk("mid-fill dreq waits in idle", 32'(d_grant), 32'd0);
    tick();
    chk("mid-fill dreq granted", 32'({d_grant, i_grant}), 32'b10);
    fill_run(1'b1, 1'b0, 16'h4000, "mid-fill dreq D");

    // i_req dropped after the first word; block at the top of memory wraps inside itself.
    i_addr = 16'hFFF8; i_req = 1'b1;
    tick();
    fill_run(1'b0, 1'b1, 16'hFFF0, "req drop");

    // Reset mid-fill after three words.
    i_addr = 16'h0200; i_req = 1'b1;
    nv = 0;
    for (int c = 0; c < 20 && nv < 3; c++) begin
      tick();
      if (i_data_vld) nv++;
    end
    chk("words before reset", 32'(nv), 32'd3);
    i_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset mid-fill");
    tick();
    rst_n = 1'b1;
    stale = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_valid) stale++;
      if (i_data_vld || d_data_vld || busy || i_done) bad++;
      tick();
    end
    chk("stale returns observed", 32'(stale), 32'd3);
    chk("stale returns ignored", 32'(bad), 32'd0);
    i_addr = 16'h0300; i_req = 1'b1;
    tick();
    chk("post-reset grant", 32'(i_grant), 32'd1);
    fill_run(1'b0, 1'b0, 16'h0300, "post-reset fill");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single multi-cycle main memory between the instruction-cache and data-cache miss handlers of the 5-stage pipeline. It serves one requester at a time:
- 8-word block fills for either cache.
- Single-word write-throughs for the data cache.

It owns every main-memory control and address line, including enable, write and address muxing, and it steers returned read words back to the granted cache.

## Interface
Parameters:
- WORDS_PER_BLK, 8: 16-bit words per cache block. Must be a power of 2. Block = WORDS_PER_BLK*2 bytes.
- ADDR_W, 16: address and data width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-cache fill request.
- i_addr  in  16  I-cache miss byte address.
- i_grant  out  1  I-cache owns memory.
- i_data_vld  out  1  rd_data/rd_word valid for the I-cache.
- i_done  out  1  I-cache fill complete (1-cycle pulse).
- d_req  in  1  D-cache request.
- d_wr  in  1  1 = single-word write, 0 = block fill.
- d_addr  in  16  D-cache byte address.
- d_wdata  in  16  write data.
- d_grant, d_data_vld, d_done  out  1 each  D-side equivalents of the I-side outputs.
- rd_data  out  16  returned word, equal to mem_rdata.
- rd_word  out  log2(WORDS_PER_BLK)  index of the returned word within the block.
- busy  out  1  state is not IDLE.
- mem_en, mem_wr  out  1  main memory enable and write.
- mem_addr, mem_wdata  out  16  main memory address and write data.
- mem_rdata  in  16  main memory read data.
- mem_valid  in  1  main memory read data valid.

## Operation
The block is a four-state FSM: IDLE, FILL, WRITE, RELEASE.

IDLE
- Samples i_req and d_req.
- A d_req with d_wr=1 goes to WRITE.
- Any other granted request goes to FILL.
- The winner is registered, along with its block base address {addr[15:4],4'h0} or, for a write, the full address and data.

FILL
- The grant output is high for the whole state.
- The issue counter runs 0..WORDS_PER_BLK-1, one read per cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*count.
- The receive counter increments on each mem_valid.
- rd_word = receive count.
- The owner's x_data_vld = mem_valid.
- When the final mem_valid arrives, x_done pulses in the same cycle, followed by RELEASE.

WRITE (one cycle)
- mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata.
- d_grant=1 and d_done=1 in this cycle.
- Next state is RELEASE.

RELEASE (one cycle)
- All grants are low and all requests are ignored.
- Requesters deassert req in response to done.
- Next state is IDLE.

Other rules:
- Arbitration: fixed priority, D over I, unless ARB_RR_EN is defined.
- Once issued, a fill cannot be cancelled. If req drops mid-fill, the fill still completes and done still pulses.
- mem_valid outside FILL is ignored. This covers stale data from reads in flight across a reset.
- While mem_en=0, mem_addr and mem_wdata are driven to 0.
- Address arithmetic is 16-bit and wraps inside the block only. Block 0xFFF0 reads 0xFFF0..0xFFFE.
- A d_req arriving while the I-cache owns memory waits; it is not preempted.

## Timing
- Reset: state IDLE, counters 0, and every output 0, including mem_en, mem_wr, all grants, data_vld, done and busy.
- Reset takes effect immediately, even mid-fill or mid-write.
- With a request seen in IDLE at cycle T:
  - Grant and the first mem_en are at T+1.
  - The last read issues at T+WORDS_PER_BLK.
  - done pulses on the last mem_valid (T+8+L for memory latency L).
  - RELEASE follows at the next cycle, and IDLE the cycle after.
- Write: granted at T+1 with done at T+1, RELEASE at T+2, IDLE at T+3.
- The minimum gap between back-to-back grants is one RELEASE cycle plus the IDLE sample cycle.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - A last_owner flop resets to D, so the first tie goes to I.
  - On a simultaneous request, the requester that was not last_owner wins.
  - last_owner updates on each grant.
- ARB_RR_EN undefined: D always wins a tie, and last_owner is not instantiated.

## Test plan
- I fill alone, i_addr=0x1236, L=4:
  - mem_addr steps 0x1230..0x123E at T+1..T+8.
  - Eight i_data_vld pulses, with rd_word 0..7 matching mem_rdata.
  - i_done at T+12 and IDLE at T+14. d_grant stays 0 throughout.
- D write, d_addr=0x0040, d_wdata=0xBEEF:
  - One cycle of mem_en=1, mem_wr=1, addr 0x0040, data 0xBEEF.
  - d_done pulses in the same cycle, then RELEASE.
- i_req and d_req (fill) rise together:
  - Without ARB_RR_EN, D is served first and I is granted after D's RELEASE.
  - With ARB_RR_EN from reset, I is served first, then D, and the next tie goes to I.
- d_req arrives mid I-fill:
  - The I-fill completes uninterrupted.
  - d_grant is 0 until IDLE, then D is granted.
- rst_n pulsed low mid-fill after 3 data words:
  - All outputs go to 0 immediately.
  - Late mem_valid pulses after release produce no data_vld.
  - A new i_req then gets a full 8-word fill.
- i_req dropped after the first word:
  - The fill still completes all 8 words and i_done pulses.
